// File: rtl/ram_responder.sv
// Byte-addressed RAM slave: serialises 8-byte data and 10-byte fetch
// accesses one byte per cycle behind a valid/ready request/response pair.
module ram_responder #(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic [79:0] resp_instr_o,
    output logic        resp_error_o
);

    localparam int AW = $clog2(DEPTH_BYTES);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_IF  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [63:0]   wdata_q;
    logic [3:0]    cnt_q;
    logic [79:0]   buf_q;
    logic          err_q;

    logic [7:0]    mem_q [DEPTH_BYTES];

    logic [3:0]    req_len;
    logic [64:0]   req_end;
    logic          req_err;
    logic          accept;
    logic [3:0]    last_cnt;
    logic [AW-1:0] byte_idx;
    logic [7:0]    rd_byte;

    // End address is formed at 65 bits so a wrapping address still errors
    always_comb begin
        req_len = (req_op_i == OP_IF) ? 4'd10 : 4'd8;
        req_end = {1'b0, req_addr_i} + {61'd0, req_len};
        req_err = (req_op_i == OP_ILL) || (req_end > 65'(DEPTH_BYTES));
    end

    assign accept   = req_valid_i && (state_q == IDLE);
    assign last_cnt = (op_q == OP_IF) ? 4'd9 : 4'd7;
    assign byte_idx = addr_q + AW'(cnt_q);
    assign rd_byte  = mem_q[byte_idx];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == last_cnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= req_op_i;
            addr_q  <= req_addr_i[AW-1:0];
            wdata_q <= req_wdata_i;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= req_err;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 4'd1;
            if (op_q != OP_WR) begin
                buf_q[{cnt_q, 3'b000} +: 8] <= rd_byte;
            end
        end
    end

    // Storage has no reset so contents survive a reset pulse
    always_ff @(posedge clk_i) begin
        if (state_q == ACCESS && op_q == OP_WR) begin
            mem_q[byte_idx] <= wdata_q[{cnt_q[2:0], 3'b000} +: 8];
        end
    end

    always_comb begin
        req_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == RESP);
        resp_error_o = 1'b0;
        resp_rdata_o = '0;
        resp_instr_o = '0;
        if (state_q == RESP) begin
            resp_error_o = err_q;
            if (!err_q && op_q == OP_RD) begin
                resp_rdata_o = buf_q[63:0];
            end
            if (!err_q && op_q == OP_IF) begin
                resp_instr_o = buf_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: byte-array reference model,
// directed boundary cases, reset abort and randomized traffic.
module tb_ram_responder;

    localparam int DEPTH = 1024;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_op_i = '0;
    logic [63:0] req_addr_i = '0;
    logic [63:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [63:0] resp_rdata_o;
    logic [79:0] resp_instr_o;
    logic        resp_error_o;

    ram_responder #(.DEPTH_BYTES(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_instr_o (resp_instr_o),
        .resp_error_o (resp_error_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int nt = 0;
    int nf = 0;

    typedef struct {
        logic [63:0] rd;
        logic [79:0] ins;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mmem [DEPTH];

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        nt++;
        nf++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_ready(output bit ok);
        int to;
        to = 0;
        while (!req_ready_o && to < 50) begin
            tick();
            to++;
        end
        ok = req_ready_o;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [63:0] addr,
                          input logic [63:0] wd, input int stall,
                          input bit tog);
        exp_t e;
        int n;
        int to;
        int ix;
        bit ok;
        logic [64:0] sum;
        req_op_i    = op;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_valid_i = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            fail_now("accept");
            req_valid_i = 1'b0;
            return;
        end
        tick();
        req_valid_i = 1'b0;
        n = (op == 2'b10) ? 10 : 8;
        sum = {1'b0, addr} + 65'(n);
        e.rd  = '0;
        e.ins = '0;
        e.err = (op == 2'b11) || (sum > 65'(DEPTH));
        e.cyc = cyc + (e.err ? 0 : n);
        if (!e.err) begin
            for (int k = 0; k < n; k++) begin
                ix = int'(addr[31:0]) + k;
                case (op)
                    2'b00: e.rd[8*k +: 8] = mmem[ix];
                    2'b10: e.ins[8*k +: 8] = mmem[ix];
                    2'b01: mmem[ix] = wd[8*k +: 8];
                    default: ;
                endcase
            end
        end
        sbq.push_back(e);
        to = 0;
        while (!resp_valid_o && to < 50) begin
            tick();
            to++;
        end
        if (!resp_valid_o) begin
            fail_now("resp_valid");
            return;
        end
        for (int s = 0; s < stall; s++) begin
            if (tog) begin
                req_valid_i = 1'b1;
                req_op_i    = 2'($urandom_range(0, 2));
                req_addr_i  = 64'($urandom_range(0, DEPTH - 16));
                req_wdata_i = {$urandom, $urandom};
            end
            chk("ready_in_resp", {79'd0, req_ready_o}, 80'd0);
            tick();
        end
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
    endtask

    logic        pv = 1'b0;
    logic [63:0] prd;
    logic [79:0] pins;
    logic        perr;
    exp_t        me;

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            pv = 1'b0;
        end else if (resp_valid_o) begin
            if (!pv) begin
                if (sbq.size() == 0) begin
                    nt++;
                    nf++;
                    $display("FAIL unexpected_resp: got response expected none");
                end else begin
                    chk("resp_edge", 80'(cyc), 80'(sbq[0].cyc));
                end
            end else begin
                chk("hold_rdata", 80'(resp_rdata_o), 80'(prd));
                chk("hold_instr", resp_instr_o, pins);
                chk("hold_error", 80'(resp_error_o), 80'(perr));
            end
            prd  = resp_rdata_o;
            pins = resp_instr_o;
            perr = resp_error_o;
            pv   = 1'b1;
            if (resp_ready_i) begin
                pv = 1'b0;
                if (sbq.size() != 0) begin
                    me = sbq.pop_front();
                    chk("rdata", 80'(resp_rdata_o), 80'(me.rd));
                    chk("instr", resp_instr_o, me.ins);
                    chk("error", 80'(resp_error_o), 80'(me.err));
                end
            end
        end else begin
            pv = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [1:0]  op;
        logic [63:0] addr;
        int r;
        for (int i = 0; i < DEPTH; i++) mmem[i] = 8'h00;

        #12;
        chk("rst_valid", 80'(resp_valid_o), 80'd0);
        chk("rst_error", 80'(resp_error_o), 80'd0);
        chk("rst_rdata", 80'(resp_rdata_o), 80'd0);
        chk("rst_instr", resp_instr_o, 80'd0);
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b1;
        tick();
        chk("ready_after_rst", 80'(req_ready_o), 80'd1);

        for (int a = 0; a < DEPTH; a += 8) do_req(2'b01, 64'(a), 64'd0, 0, 1'b0);

        do_req(2'b01, 64'h10, 64'h1122334455667788, 0, 1'b0);
        do_req(2'b00, 64'h10, 64'd0, 1, 1'b0);
        do_req(2'b10, 64'h0E, 64'd0, 0, 1'b0);

        do_req(2'b00, 64'(DEPTH - 8), 64'd0, 0, 1'b0);
        do_req(2'b00, 64'(DEPTH - 7), 64'd0, 0, 1'b0);
        do_req(2'b10, 64'(DEPTH - 10), 64'd0, 0, 1'b0);
        do_req(2'b10, 64'(DEPTH - 9), 64'd0, 0, 1'b0);
        do_req(2'b00, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0, 1'b0);
        do_req(2'b11, 64'h40, 64'd0, 0, 1'b0);

        do_req(2'b00, 64'h10, 64'd0, 5, 1'b1);

        do_req(2'b01, 64'h20, 64'h0102030405060708, 0, 1'b0);
        req_op_i    = 2'b01;
        req_addr_i  = 64'h20;
        req_wdata_i = 64'hAAAA_AAAA_AAAA_AAAA;
        req_valid_i = 1'b1;
        wait_ready(ok);
        if (!ok) fail_now("abort_accept");
        tick();
        req_valid_i = 1'b0;
        repeat (3) tick();
        rst_n_i = 1'b0;
        for (int k = 0; k < 3; k++) mmem[32 + k] = 8'hAA;
        tick();
        chk("abort_valid", 80'(resp_valid_o), 80'd0);
        chk("abort_rdata", 80'(resp_rdata_o), 80'd0);
        tick();
        rst_n_i = 1'b1;
        tick();
        chk("abort_ready", 80'(req_ready_o), 80'd1);
        repeat (12) tick();
        do_req(2'b00, 64'h20, 64'd0, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 2'b11
                                             : 2'($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            if (r < 8) addr = 64'($urandom_range(0, DEPTH - 1));
            else if (r == 8) addr = 64'(DEPTH - 16 + $urandom_range(0, 15));
            else addr = {$urandom, $urandom};
            do_req(op, addr, {$urandom, $urandom},
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (4) tick();
        chk("scoreboard_empty", 80'(sbq.size()), 80'd0);
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH_BYTES, default 1024, meaning byte capacity of storage; it SHALL be a power of two and at least 16.
REQ-002 clk_i  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  the initiator presents a request.
REQ-005 req_ready_o  output  1  the responder can accept a request.
REQ-006 req_op_i  input  2  operation: 00 read data (8 B), 01 write data (8 B), 10 instruction fetch (10 B), 11 illegal.
REQ-007 req_addr_i  input  64  byte address of the first byte.
REQ-008 req_wdata_i  input  64  write data, little-endian.
REQ-009 resp_valid_o  output  1  a response is presented.
REQ-010 resp_ready_i  input  1  the initiator accepts the response.
REQ-011 resp_rdata_o  output  64  read data, little-endian.
REQ-012 resp_instr_o  output  80  fetched instruction bytes, little-endian.
REQ-013 resp_error_o  output  1  the request failed; qualified by resp_valid_o.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted on an edge where req_valid_i=1 and req_ready_o=1; op, addr and wdata SHALL be captured at that edge, and later input changes SHALL have no effect.
REQ-016 Length N SHALL be 8 for op 00/01 and 10 for op 10.
REQ-017 An error SHALL be flagged when op=11 or addr+N > DEPTH_BYTES, with the sum computed at 65 bits so wrap-around cannot mask overflow.
REQ-018 On an error, the FSM SHALL go IDLE->RESP with resp_error_o=1 and all data outputs 0; storage SHALL NOT be touched.
REQ-019 Without an error, the FSM SHALL go IDLE->ACCESS, and a 4-bit byte counter SHALL start at 0.
REQ-020 In ACCESS, one byte SHALL be transferred per cycle at addr+counter.
REQ-021 The counter SHALL increment once per cycle.
REQ-022 After the byte at counter=N-1, the FSM SHALL go to RESP, so resp_valid_o rises on the (N+1)th edge after acceptance.
REQ-023 For a read, byte addr+k SHALL be placed in resp_rdata_o[8k+7:8k], and resp_instr_o SHALL be 0.
REQ-024 For a fetch, byte addr+k SHALL be placed in resp_instr_o[8k+7:8k], and resp_rdata_o SHALL be 0.
REQ-025 For a write, req_wdata_i[8k+7:8k] SHALL be written to byte addr+k; the response SHALL carry resp_error_o=0 and zero data.
REQ-026 In RESP, all response outputs SHALL hold stable until resp_ready_i=1.
REQ-027 On the edge where resp_valid_o=1 and resp_ready_i=1, the FSM SHALL return to IDLE; the next request SHALL be accepted no earlier than the following edge.
REQ-028 req_valid_i asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-029 resp_ready_i asserted outside RESP SHALL be ignored.
REQ-030 Storage SHALL be byte-wide, synchronous write; a read SHALL return data from the most recent completed write.

Reset
REQ-031 While rst_n_i=0, the state SHALL be IDLE, the counter 0, resp_valid_o=0, resp_error_o=0, resp_rdata_o=0 and resp_instr_o=0.
REQ-032 req_ready_o SHALL be 1 one edge after rst_n_i deasserts.
REQ-033 Storage contents SHALL NOT be cleared by reset.
REQ-034 A reset asserted mid-ACCESS SHALL abort the access immediately.
REQ-035 Bytes already written before an aborted access SHALL remain; no response SHALL be produced for the aborted request.

Verification
REQ-036 Write 0x1122334455667788 to addr 0x10, then read 0x10 -> write response error=0 on edge 9; read response rdata=0x1122334455667788 on edge 9; byte 0x10 = 0x88.
REQ-037 After the REQ-036 write, fetch at addr 0x0E -> resp_instr_o[15:0]=0 (prior contents, pre-loaded 0), resp_instr_o[79:16]=0x1122334455667788; resp_valid_o on edge 11.
REQ-038 Read at addr DEPTH_BYTES-8 succeeds; read at DEPTH_BYTES-7 -> error=1 on edge 1; read at 0xFFFFFFFFFFFFFFFC -> error=1 with no wrap; op=11 -> error=1.
REQ-039 Hold resp_ready_i=0 for 5 cycles in RESP while toggling req_valid_i and the request inputs -> response outputs stable, req_ready_o=0, no second request accepted.
REQ-040 Assert rst_n_i=0 at counter=3 of a write of 0xAAAAAAAAAAAAAAAA to 0x20, then read 0x20 -> bytes 0x20..0x22 = 0xAA, 0x23..0x27 unchanged, no stale response after reset.
